// File: rtl/arith_unit_pkg.sv
// Shared definitions for the arithmetic-unit magnitude datapath.
//  - AU_W        : magnitude width (spec bit 1 = MSB, bit W = LSB)
//  - AU_MSB_IDX  : vector index holding bit 1 (MSB, weight 2^-1)
//  - AU_LSB_IDX  : vector index holding bit W (LSB)
//  - au_op_t     : bundle of the single-cycle do_* pulses from the sequencer
// Vectors are stored [W-1:0], so index W-1 is bit 1 and index 0 is bit W.
package arith_unit_pkg;

  localparam int AU_W       = 30;
  localparam int AU_MSB_IDX = AU_W - 1;
  localparam int AU_LSB_IDX = 0;

  typedef struct packed {
    logic clear_a;
    logic clear_b;
    logic clear_c;
    logic not_a;
    logic not_b;
    logic sum;
    logic and_c;
    logic set_c_30;
    logic left_shift_b;
    logic left_shift_c;
    logic left_shift_c29;
    logic right_shift_bc;
    logic move_c_to_a;
    logic move_c_to_b;
    logic move_b_to_c;
    logic mem_to_c;
    logic arr_c;
  } au_op_t;

endpackage

// File: rtl/arith_unit_adder.sv
// au_adder: W-bit magnitude adder with optional end-around carry.
// Ports:
//  a_i, b_i       in  W  operands
//  end_around_i   in  1  fold the carry back into the LSB (ones' complement)
//  sum_o          out W  result (end-around applied when enabled)
//  carry_o        out 1  raw carry out of the MSB, before any end-around
module au_adder #(
  parameter int W = 30
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         end_around_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W:0] raw_sum;

  assign raw_sum = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = raw_sum[W];
  assign sum_o   = end_around_i ? (raw_sum[W-1:0] + {{(W-1){1'b0}}, raw_sum[W]})
                                : raw_sum[W-1:0];

endmodule

// File: rtl/arith_unit.sv
// arith_unit: magnitude datapath holding registers A, C (W bits) and
// B (W bits plus overflow bit B0). Executes single-cycle do_* pulses from
// the program sequencer and returns status levels to steer it.
// Ports:
//  clk, reset            clock; synchronous active-high reset
//  do_*                  operation pulses (do_mem_to_c/do_arr_c are levels)
//  mem_data_in, arr_c_in memory word / panel switch word loaded into C
//  shift_in_from_io      serial fill bit for C left shifts (with do_left_shift_c29)
//  carry_out             combinational carry out of bit 1 of A + B operand
//  reg_c1/reg_c30/reg_b0 C MSB, C LSB, overflow bit
//  reg_a/reg_b/reg_c     register contents; reg_b = {B0, B[1:W]}
//  inv_a                 A holds its complement, sums use end-around carry
module arith_unit
  import arith_unit_pkg::*;
#(
  parameter int W = AU_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         do_clear_a,
  input  logic         do_clear_b,
  input  logic         do_clear_c,
  input  logic         do_not_a,
  input  logic         do_not_b,
  input  logic         do_sum,
  input  logic         do_and,
  input  logic         do_set_c_30,
  input  logic         do_left_shift_b,
  input  logic         do_left_shift_c,
  input  logic         do_left_shift_c29,
  input  logic         do_right_shift_bc,
  input  logic         do_move_c_to_a,
  input  logic         do_move_c_to_b,
  input  logic         do_move_b_to_c,
  input  logic         do_mem_to_c,
  input  logic         do_arr_c,
  input  logic [W-1:0] mem_data_in,
  input  logic [W-1:0] arr_c_in,
  input  logic         shift_in_from_io,
  output logic         carry_out,
  output logic         reg_c1,
  output logic         reg_c30,
  output logic         reg_b0,
  output logic [W-1:0] reg_a,
  output logic [W:0]   reg_b,
  output logic [W-1:0] reg_c,
  output logic         inv_a
);

  au_op_t op;

  assign op.clear_a        = do_clear_a;
  assign op.clear_b        = do_clear_b;
  assign op.clear_c        = do_clear_c;
  assign op.not_a          = do_not_a;
  assign op.not_b          = do_not_b;
  assign op.sum            = do_sum;
  assign op.and_c          = do_and;
  assign op.set_c_30       = do_set_c_30;
  assign op.left_shift_b   = do_left_shift_b;
  assign op.left_shift_c   = do_left_shift_c;
  assign op.left_shift_c29 = do_left_shift_c29;
  assign op.right_shift_bc = do_right_shift_bc;
  assign op.move_c_to_a    = do_move_c_to_a;
  assign op.move_c_to_b    = do_move_c_to_b;
  assign op.move_b_to_c    = do_move_b_to_c;
  assign op.mem_to_c       = do_mem_to_c;
  assign op.arr_c          = do_arr_c;

  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic         b0_q, b0_d, inv_q, inv_d;
  logic [W-1:0] b_operand, add_sum;
  logic         add_carry, c_fill;

  // not_b in the same cycle as sum feeds the complemented B into the adder.
  assign b_operand = (op.not_b && op.sum) ? ~b_q : b_q;

  au_adder #(.W(W)) u_adder (
    .a_i          (a_q),
    .b_i          (b_operand),
    .end_around_i (inv_q),
    .sum_o        (add_sum),
    .carry_o      (add_carry)
  );

  // A register and its complement-tracking flag.
  always_comb begin
    a_d   = a_q;
    inv_d = inv_q;
    if (op.clear_a) begin
      a_d   = '0;
      inv_d = 1'b0;
    end else if (op.move_c_to_a) begin
      a_d   = c_q;
      inv_d = 1'b0;
    end else if (op.not_a) begin
      a_d   = ~a_q;
      inv_d = ~inv_q;
    end
  end

  // B register plus overflow bit B0.
  always_comb begin
    b_d  = b_q;
    b0_d = b0_q;
    if (op.clear_b) begin
      b_d  = '0;
      b0_d = 1'b0;
    end else if (op.move_c_to_b) begin
      b_d  = c_q;
      b0_d = 1'b0;
    end else if (op.sum) begin
      b_d  = add_sum;
      // End-around already consumed the carry, so no overflow is recorded.
      b0_d = inv_q ? 1'b0 : add_carry;
    end else if (op.right_shift_bc) begin
      b_d  = {b0_q, b_q[W-1:1]};
      b0_d = 1'b0;
    end else if (op.left_shift_b) begin
      b_d  = {b_q[W-2:0], 1'b0};
      b0_d = b_q[AU_MSB_IDX];
    end else if (op.not_b) begin
      b_d  = ~b_q;
    end
  end

  // C register. set_c_30 during a left shift forces the fill bit to 1.
  assign c_fill = (op.left_shift_c29 & shift_in_from_io) | op.set_c_30;

  always_comb begin
    c_d = c_q;
    if (op.move_b_to_c) begin
      c_d = b_q;
    end else if (op.and_c) begin
      c_d = a_q & c_q;
    end else if (op.right_shift_bc) begin
      c_d = {b_q[AU_LSB_IDX], c_q[W-1:1]};
    end else if (op.left_shift_c) begin
      c_d = {c_q[W-2:0], c_fill};
    end else if (op.set_c_30) begin
      c_d[AU_LSB_IDX] = 1'b1;
    end else if (op.mem_to_c) begin
      c_d = mem_data_in;
    end else if (op.arr_c) begin
      c_d = arr_c_in;
    end else if (op.clear_c) begin
      c_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      b0_q  <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      b0_q  <= b0_d;
      inv_q <= inv_d;
    end
  end

  assign carry_out = add_carry;
  assign reg_c1    = c_q[AU_MSB_IDX];
  assign reg_c30   = c_q[AU_LSB_IDX];
  assign reg_b0    = b0_q;
  assign reg_a     = a_q;
  assign reg_b     = {b0_q, b_q};
  assign reg_c     = c_q;
  assign inv_a     = inv_q;

endmodule

// File: tb/tb_arith_unit.sv
module tb_arith_unit;

  localparam int W = 30;

  logic         clk = 1'b0;
  logic         reset;
  logic         do_clear_a, do_clear_b, do_clear_c, do_not_a, do_not_b, do_sum;
  logic         do_and, do_set_c_30, do_left_shift_b, do_left_shift_c, do_left_shift_c29;
  logic         do_right_shift_bc, do_move_c_to_a, do_move_c_to_b, do_move_b_to_c;
  logic         do_mem_to_c, do_arr_c;
  logic [W-1:0] mem_data_in, arr_c_in;
  logic         shift_in_from_io;
  logic         carry_out, reg_c1, reg_c30, reg_b0, inv_a;
  logic [W-1:0] reg_a, reg_c;
  logic [W:0]   reg_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  arith_unit dut (
    .clk               (clk),
    .reset             (reset),
    .do_clear_a        (do_clear_a),
    .do_clear_b        (do_clear_b),
    .do_clear_c        (do_clear_c),
    .do_not_a          (do_not_a),
    .do_not_b          (do_not_b),
    .do_sum            (do_sum),
    .do_and            (do_and),
    .do_set_c_30       (do_set_c_30),
    .do_left_shift_b   (do_left_shift_b),
    .do_left_shift_c   (do_left_shift_c),
    .do_left_shift_c29 (do_left_shift_c29),
    .do_right_shift_bc (do_right_shift_bc),
    .do_move_c_to_a    (do_move_c_to_a),
    .do_move_c_to_b    (do_move_c_to_b),
    .do_move_b_to_c    (do_move_b_to_c),
    .do_mem_to_c       (do_mem_to_c),
    .do_arr_c          (do_arr_c),
    .mem_data_in       (mem_data_in),
    .arr_c_in          (arr_c_in),
    .shift_in_from_io  (shift_in_from_io),
    .carry_out         (carry_out),
    .reg_c1            (reg_c1),
    .reg_c30           (reg_c30),
    .reg_b0            (reg_b0),
    .reg_a             (reg_a),
    .reg_b             (reg_b),
    .reg_c             (reg_c),
    .inv_a             (inv_a)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pulses(input logic v);
    do_clear_a = v; do_clear_b = v; do_clear_c = v; do_not_a = v; do_not_b = v;
    do_sum = v; do_and = v; do_set_c_30 = v; do_left_shift_b = v; do_left_shift_c = v;
    do_left_shift_c29 = v; do_right_shift_bc = v; do_move_c_to_a = v;
    do_move_c_to_b = v; do_move_b_to_c = v; do_mem_to_c = v; do_arr_c = v;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    set_pulses(1'b0);
  endtask

  task automatic load_c(input logic [W-1:0] v);
    arr_c_in = v; do_arr_c = 1'b1; step();
  endtask

  task automatic load_a(input logic [W-1:0] v);
    load_c(v); do_move_c_to_a = 1'b1; step();
  endtask

  task automatic load_b(input logic [W-1:0] v);
    load_c(v); do_move_c_to_b = 1'b1; step();
  endtask

  initial begin
    logic exp_c1 [3];
    exp_c1[0] = 1'b1; exp_c1[1] = 1'b0; exp_c1[2] = 1'b0;

    mem_data_in = 30'h2AAA_AAAA; arr_c_in = 30'h1555_5555; shift_in_from_io = 1'b1;
    reset = 1'b1;
    set_pulses(1'b1);
    @(posedge clk); #1;
    step();
    check("reset_a", reg_a, 0);
    check("reset_b", reg_b, 0);
    check("reset_c", reg_c, 0);
    check("reset_inv_a", inv_a, 0);
    check("reset_carry", carry_out, 0);
    check("reset_b0", reg_b0, 0);
    reset = 1'b0;
    shift_in_from_io = 1'b0;

    // Plain add, no carry.
    load_a(30'h1000_0000);
    load_b(30'h0800_0000);
    do_sum = 1'b1; #1;
    check("sum1_carry_pre", carry_out, 0);
    step();
    check("sum1_b", reg_b, 32'h1800_0000);
    check("sum1_b0", reg_b0, 0);

    // Overflow into B0.
    load_a(30'h3FFF_FFFF);
    load_b(30'h1);
    do_sum = 1'b1; #1;
    check("sum2_carry_pre", carry_out, 1);
    step();
    check("sum2_b", reg_b, 32'h4000_0000);
    check("sum2_b0", reg_b0, 1);

    // Ones' complement subtract with end-around carry.
    load_a(30'h5);
    do_not_a = 1'b1; step();
    check("not_a_val", reg_a, 32'h3FFF_FFFA);
    check("not_a_inv", inv_a, 1);
    load_b(30'h9);
    do_sum = 1'b1; step();
    check("sub_b", reg_b, 32'h4);
    do_clear_a = 1'b1; step();
    check("clear_a_inv", inv_a, 0);
    check("clear_a_val", reg_a, 0);

    // Left shift B into B0, then joint right shift of B and C.
    load_b(30'h2000_0001);
    do_left_shift_b = 1'b1; step();
    check("lsb_b", reg_b, 32'h4000_0002);
    load_c(30'h3);
    do_right_shift_bc = 1'b1; step();
    check("rsbc_b", reg_b, 32'h2000_0001);
    check("rsbc_c", reg_c, 32'h1);

    // Serial left shift of C with input fill.
    load_c(30'h2000_0000);
    shift_in_from_io = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lsc_c1_%0d", i), reg_c1, exp_c1[i]);
      do_left_shift_c = 1'b1; do_left_shift_c29 = 1'b1; step();
    end
    shift_in_from_io = 1'b0;
    check("lsc_c", reg_c, 32'h7);
    check("lsc_c30", reg_c30, 1);

    // Simultaneous moves swap B and C.
    load_b(30'h123);
    load_c(30'h456);
    do_move_c_to_b = 1'b1; do_move_b_to_c = 1'b1; step();
    check("swap_b", reg_b, 32'h456);
    check("swap_c", reg_c, 32'h123);

    // not_b together with sum uses the complemented B.
    load_a(30'h1);
    load_b(30'h3FFF_FFF0);
    do_not_b = 1'b1; do_sum = 1'b1; step();
    check("notb_sum_b", reg_b, 32'h10);
    do_not_b = 1'b1; step();
    check("notb_alone", reg_b, 32'h3FFF_FFEF);

    // clear_b beats sum.
    do_clear_b = 1'b1; do_sum = 1'b1; step();
    check("clrb_prio", reg_b, 0);

    // AND into C.
    load_a(30'hF0);
    load_c(30'h3C);
    do_and = 1'b1; step();
    check("and_c", reg_c, 32'h30);

    // Left shift plus set_c_30 ends with LSB forced high.
    load_c(30'h1);
    do_left_shift_c = 1'b1; do_set_c_30 = 1'b1; step();
    check("lsc_set", reg_c, 32'h3);

    // mem_to_c beats arr_c; arr_c beats clear_c; clear_c alone zeroes.
    mem_data_in = 30'h155; arr_c_in = 30'h2AA;
    do_mem_to_c = 1'b1; do_arr_c = 1'b1; step();
    check("mem_prio", reg_c, 32'h155);
    do_arr_c = 1'b1; do_clear_c = 1'b1; step();
    check("arr_prio", reg_c, 32'h2AA);
    do_clear_c = 1'b1; step();
    check("clear_c", reg_c, 0);

    // Reset mid-operation wins over pulses.
    load_a(30'h7);
    do_not_a = 1'b1; step();
    load_b(30'h9);
    reset = 1'b1; do_sum = 1'b1; do_arr_c = 1'b1; do_not_a = 1'b1; step();
    reset = 1'b0;
    check("rst_mid_a", reg_a, 0);
    check("rst_mid_b", reg_b, 0);
    check("rst_mid_c", reg_c, 0);
    check("rst_mid_inv", inv_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
